// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: datapath width,
// FSM state encodings and the latched-operand payload.
package adder_arbiter_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
        logic              id;
    } operand_t;

endpackage

// File: rtl/adder_32.sv
// 32-bit ripple-carry adder shared by both requesters of adder_arbiter.
module adder_32
    import adder_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Cin,
    output logic [DATA_W-1:0] S,
    output logic              Cout
);

    logic [DATA_W:0] carry;

    assign carry[0] = Cin;

    for (genvar i = 0; i < int'(DATA_W); i++) begin : g_bit
        assign S[i]         = A[i] ^ B[i] ^ carry[i];
        assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = carry[DATA_W];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared 32-bit adder;
// a single result slot holds the sum until the consumer takes it.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_cin,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_cin,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_sum,
    output logic              resp_cout,

    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
);

    state_e   state;
    operand_t ops;
    operand_t next_ops;
    logic     last_grant;
    logic     grant_id;
    logic     slot_free;
    logic     accept;

    assign slot_free = (state == IDLE) || resp_ready;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign req0_ready = !reset && slot_free && req0_valid && !grant_id;
    assign req1_ready = !reset && slot_free && req1_valid &&  grant_id;
    assign accept     = req0_ready || req1_ready;

    // Only the granted requester's operands are steered into the slot.
    always_comb begin
        next_ops = ops;
        if (grant_id) begin
            next_ops = '{a: req1_a, b: req1_b, cin: req1_cin, id: 1'b1};
        end else begin
            next_ops = '{a: req0_a, b: req0_b, cin: req0_cin, id: 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ops        <= '0;
            last_grant <= 1'b1;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (accept) begin
                state      <= FULL;
                ops        <= next_ops;
                last_grant <= grant_id;
                if (grant_id) begin
                    grant_cnt1 <= grant_cnt1 + CNT_W'(1);
                end else begin
                    grant_cnt0 <= grant_cnt0 + CNT_W'(1);
                end
            end else if ((state == FULL) && resp_ready) begin
                state <= IDLE;
            end
        end
    end

    // Sum is formed from registered operands, so resp_* never sees resp_ready.
    adder_32 u_adder (
        .A    (ops.a),
        .B    (ops.b),
        .Cin  (ops.cin),
        .S    (resp_sum),
        .Cout (resp_cout)
    );

    assign resp_valid = (state == FULL);
    assign resp_id    = ops.id;

endmodule
